// File: rtl/mcycle_hazard_ctrl_if.sv
// Pipeline-side signal bundle for the stall/flush sequencer: hazard inputs from
// Decode/Execute, multi-cycle unit handshake, and the stall/flush controls it drives.
interface mcycle_hazard_ctrl_if #(
   parameter int unsigned CNT_W = 8
);
   logic             M_StartE;
   logic             mc_done;
   logic             MemtoRegE;
   logic             RegWE;
   logic [3:0]       WA3E;
   logic [3:0]       RA1D;
   logic [3:0]       RA2D;
   logic             PCSrcE;
   logic             mc_start;
   logic             StallF;
   logic             StallD;
   logic             StallE;
   logic             FlushD;
   logic             FlushE;
   logic             mc_busy;
   logic             mc_timeout;
   logic [CNT_W-1:0] busy_cnt;

   modport master (
      output M_StartE, mc_done, MemtoRegE, RegWE, WA3E, RA1D, RA2D, PCSrcE,
      input  mc_start, StallF, StallD, StallE, FlushD, FlushE, mc_busy, mc_timeout, busy_cnt
   );

   modport slave (
      input  M_StartE, mc_done, MemtoRegE, RegWE, WA3E, RA1D, RA2D, PCSrcE,
      output mc_start, StallF, StallD, StallE, FlushD, FlushE, mc_busy, mc_timeout, busy_cnt
   );
endinterface

// File: rtl/mcycle_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: issues and tracks MUL/DIV ops held in
// Execute (IDLE/WAIT/COMMIT with watchdog) and resolves load-use and taken-branch hazards.
module mcycle_hazard_ctrl #(
   parameter int unsigned CNT_W          = 8,
   parameter int unsigned TIMEOUT_CYCLES = 200
) (
   input logic                 clk,
   input logic                 rst_n,
   mcycle_hazard_ctrl_if.slave bus
);
   typedef enum logic [1:0] {IDLE, WAIT, COMMIT} state_e;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [31:0]      TO_LAST = 32'(TIMEOUT_CYCLES) - 32'd1;

   state_e           state_q;
   logic [CNT_W-1:0] busy_cnt_q;
   logic             mc_timeout_q;

   logic lwstall;
   logic wd_hit;
   logic mc_start, stall_f, stall_d, stall_e, flush_d, flush_e, mc_busy;

   assign lwstall = bus.MemtoRegE & bus.RegWE &
                    ((bus.WA3E == bus.RA1D) | (bus.WA3E == bus.RA2D));

   // The last WAIT cycle (done or watchdog) does not count, so busy_cnt = N-1 at COMMIT.
   assign wd_hit = (TIMEOUT_CYCLES != 0) && (32'(busy_cnt_q) >= TO_LAST);

   // NOTE: sequential state uses non-blocking assignments only; combinational logic below uses blocking.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         busy_cnt_q   <= '0;
         mc_timeout_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.M_StartE) begin
                  state_q    <= WAIT;
                  busy_cnt_q <= '0;
               end
            end
            WAIT: begin
               if (bus.mc_done) begin
                  state_q <= COMMIT;
               end else if (wd_hit) begin
                  state_q      <= COMMIT;
                  mc_timeout_q <= 1'b1;
               end else if (busy_cnt_q != CNT_MAX) begin
                  busy_cnt_q <= busy_cnt_q + 1'b1;
               end
            end
            COMMIT:  state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   // NOTE: every output gets a default first so no path can infer a latch.
   always_comb begin
      mc_start = 1'b0;
      stall_f  = 1'b0;
      stall_d  = 1'b0;
      stall_e  = 1'b0;
      flush_d  = 1'b0;
      flush_e  = 1'b0;
      mc_busy  = 1'b0;
      // Reset holds state in IDLE, so the live hazard path must be gated explicitly.
      if (rst_n) begin
         case (state_q)
            IDLE: begin
               if (bus.M_StartE) begin
                  mc_start = 1'b1;
                  stall_f  = 1'b1;
                  stall_d  = 1'b1;
                  stall_e  = 1'b1;
                  mc_busy  = 1'b1;
               end else begin
                  stall_f = lwstall;
                  stall_d = lwstall;
                  flush_e = lwstall | bus.PCSrcE;
                  flush_d = bus.PCSrcE;
               end
            end
            WAIT: begin
               stall_f = 1'b1;
               stall_d = 1'b1;
               stall_e = 1'b1;
               mc_busy = 1'b1;
            end
            COMMIT: begin
               flush_d = bus.PCSrcE;
               flush_e = bus.PCSrcE;
            end
            default: ;
         endcase
      end
   end

   assign bus.mc_start   = mc_start;
   assign bus.StallF     = stall_f;
   assign bus.StallD     = stall_d;
   assign bus.StallE     = stall_e;
   assign bus.FlushD     = flush_d;
   assign bus.FlushE     = flush_e;
   assign bus.mc_busy    = mc_busy;
   assign bus.mc_timeout = mc_timeout_q;
   assign bus.busy_cnt   = busy_cnt_q;
endmodule

// File: tb/tb_mcycle_hazard_ctrl.sv
// Directed bench for mcycle_hazard_ctrl: IDLE hazard vector table plus hand-written
// multi-cycle, watchdog and mid-operation reset sequences.
module tb_mcycle_hazard_ctrl;
   localparam int unsigned CNT_W = 8;
   localparam int unsigned TO    = 10;

   // Output bundle order: {mc_start, StallF, StallD, StallE, FlushD, FlushE, mc_busy}
   localparam logic [6:0] O_NONE  = 7'b0000000;
   localparam logic [6:0] O_ISSUE = 7'b1111001;
   localparam logic [6:0] O_WAIT  = 7'b0111001;
   localparam logic [6:0] O_LW    = 7'b0110010;
   localparam logic [6:0] O_BR    = 7'b0000110;
   localparam logic [6:0] O_LWBR  = 7'b0110110;

   typedef struct {
      string      name;
      logic       mc_done;
      logic       MemtoRegE;
      logic       RegWE;
      logic [3:0] WA3E;
      logic [3:0] RA1D;
      logic [3:0] RA2D;
      logic       PCSrcE;
      logic [6:0] exp_o;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;
   vec_t vecs[9];

   always #5 clk = ~clk;

   mcycle_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

   mcycle_hazard_ctrl #(
      .CNT_W         (CNT_W),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus.slave)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
      end
   endtask

   function automatic logic [6:0] outs();
      return {bus.mc_start, bus.StallF, bus.StallD, bus.StallE, bus.FlushD, bus.FlushE, bus.mc_busy};
   endfunction

   task automatic set_in(input logic m, input logic d, input logic ml, input logic rw,
                         input logic [3:0] wa, input logic [3:0] r1, input logic [3:0] r2,
                         input logic pc);
      bus.M_StartE  = m;
      bus.mc_done   = d;
      bus.MemtoRegE = ml;
      bus.RegWE     = rw;
      bus.WA3E      = wa;
      bus.RA1D      = r1;
      bus.RA2D      = r2;
      bus.PCSrcE    = pc;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_o(input string name, input logic [6:0] e);
      #2;
      check(name, 32'(outs()), 32'(e));
   endtask

   initial begin
      vecs[0] = '{"lw_ra2",        1'b0, 1'b1, 1'b1, 4'd3, 4'd0, 4'd3, 1'b0, O_LW};
      vecs[1] = '{"lw_nomatch",    1'b0, 1'b1, 1'b1, 4'd3, 4'd5, 4'd5, 1'b0, O_NONE};
      vecs[2] = '{"lw_and_branch", 1'b0, 1'b1, 1'b1, 4'd3, 4'd0, 4'd3, 1'b1, O_LWBR};
      vecs[3] = '{"branch_only",   1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b1, O_BR};
      vecs[4] = '{"load_no_we",    1'b0, 1'b1, 1'b0, 4'd7, 4'd7, 4'd7, 1'b0, O_NONE};
      vecs[5] = '{"we_not_load",   1'b0, 1'b0, 1'b1, 4'd7, 4'd7, 4'd7, 1'b0, O_NONE};
      vecs[6] = '{"lw_ra1_done",   1'b1, 1'b1, 1'b1, 4'd9, 4'd9, 4'd2, 1'b0, O_LW};
      vecs[7] = '{"lw_r0",         1'b0, 1'b1, 1'b1, 4'd0, 4'd0, 4'd0, 1'b0, O_LW};
      vecs[8] = '{"idle_done",     1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, O_NONE};

      // Reset with every input trying to assert something
      set_in(1'b1, 1'b1, 1'b1, 1'b1, 4'd3, 4'd3, 4'd3, 1'b1);
      expect_o("reset_outs", O_NONE);
      check("reset_busy_cnt", 32'(bus.busy_cnt), 32'd0);
      check("reset_timeout", 32'(bus.mc_timeout), 32'd0);
      tick();
      expect_o("reset_outs_2", O_NONE);

      // Release reset with M_StartE=1: op with mc_done 5 cycles after mc_start
      set_in(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0);
      rst_n = 1'b1;
      expect_o("issue_after_reset", O_ISSUE);
      tick();
      bus.M_StartE = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         expect_o($sformatf("mc_wait_%0d", k), O_WAIT);
         check($sformatf("mc_cnt_%0d", k), 32'(bus.busy_cnt), 32'(k - 1));
         tick();
      end
      bus.mc_done = 1'b1;
      expect_o("mc_wait_5_done", O_WAIT);
      tick();
      bus.mc_done  = 1'b0;
      bus.M_StartE = 1'b1;
      expect_o("mc_commit", O_NONE);
      check("mc_commit_cnt", 32'(bus.busy_cnt), 32'd4);
      tick();
      bus.M_StartE = 1'b0;
      expect_o("mc_back_idle", O_NONE);
      check("mc_cnt_held", 32'(bus.busy_cnt), 32'd4);
      tick();

      // IDLE hazard table
      foreach (vecs[i]) begin
         set_in(1'b0, vecs[i].mc_done, vecs[i].MemtoRegE, vecs[i].RegWE,
                vecs[i].WA3E, vecs[i].RA1D, vecs[i].RA2D, vecs[i].PCSrcE);
         expect_o(vecs[i].name, vecs[i].exp_o);
         tick();
      end

      // mc_done in the issue cycle is ignored; PCSrcE in COMMIT is honoured
      set_in(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0);
      expect_o("issue_with_done", O_ISSUE);
      tick();
      set_in(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0);
      expect_o("done_at_issue_ignored", O_WAIT);
      tick();
      bus.mc_done = 1'b1;
      expect_o("short_op_done", O_WAIT);
      tick();
      bus.mc_done = 1'b0;
      bus.PCSrcE  = 1'b1;
      expect_o("commit_pcsrc", O_BR);
      check("short_op_cnt", 32'(bus.busy_cnt), 32'd1);
      tick();
      bus.PCSrcE = 1'b0;

      // Watchdog: no mc_done, timeout after TO WAIT cycles
      bus.M_StartE = 1'b1;
      expect_o("wd_issue", O_ISSUE);
      tick();
      bus.M_StartE = 1'b0;
      for (int k = 1; k <= int'(TO); k++) begin
         expect_o($sformatf("wd_wait_%0d", k), O_WAIT);
         check($sformatf("wd_flag_low_%0d", k), 32'(bus.mc_timeout), 32'd0);
         tick();
      end
      expect_o("wd_commit", O_NONE);
      check("wd_flag_set", 32'(bus.mc_timeout), 32'd1);
      check("wd_commit_cnt", 32'(bus.busy_cnt), 32'(TO - 1));
      tick();
      bus.M_StartE = 1'b1;
      expect_o("wd_reissue", O_ISSUE);
      check("wd_flag_sticky", 32'(bus.mc_timeout), 32'd1);
      tick();
      bus.M_StartE = 1'b0;
      bus.mc_done  = 1'b1;
      expect_o("wd_second_wait", O_WAIT);
      tick();
      bus.mc_done = 1'b0;
      expect_o("wd_second_commit", O_NONE);
      check("wd_second_cnt", 32'(bus.busy_cnt), 32'd0);
      check("wd_flag_still", 32'(bus.mc_timeout), 32'd1);
      tick();

      // Reset pulse in WAIT cycle 3 abandons the op
      bus.M_StartE = 1'b1;
      expect_o("rst_issue", O_ISSUE);
      tick();
      bus.M_StartE = 1'b0;
      for (int k = 1; k <= 2; k++) begin
         expect_o($sformatf("rst_wait_%0d", k), O_WAIT);
         tick();
      end
      expect_o("rst_wait_3", O_WAIT);
      check("rst_cnt_before", 32'(bus.busy_cnt), 32'd2);
      rst_n = 1'b0;
      #1;
      check("rst_mid_outs", 32'(outs()), 32'(O_NONE));
      check("rst_mid_cnt", 32'(bus.busy_cnt), 32'd0);
      check("rst_mid_timeout", 32'(bus.mc_timeout), 32'd0);
      #1;
      rst_n = 1'b1;
      tick();
      bus.mc_done = 1'b1;
      expect_o("late_done_idle", O_NONE);
      tick();
      set_in(1'b0, 1'b0, 1'b1, 1'b1, 4'd4, 4'd4, 4'd1, 1'b0);
      expect_o("late_done_no_commit", O_LW);
      check("late_done_cnt", 32'(bus.busy_cnt), 32'd0);
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/mcycle_hazard_ctrl.md
Name: mcycle_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline.
- Drives the Stall and refresh inputs of the F/D, D→E and E→M pipeline registers.
- Issues and tracks multi-cycle (MUL/DIV) operations held in Execute.
- Also resolves load-use hazards and taken-branch flushes, with a watchdog on the multi-cycle unit.

Parameters:
- CNT_W, 8, width of the busy-cycle counter.
- TIMEOUT_CYCLES, 200, WAIT cycles before forced abort; 0 disables the watchdog.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- M_StartE  in  1  Execute instruction is a condition-passed multi-cycle op.
- mc_done  in  1  one-cycle pulse from the multi-cycle unit: result valid.
- MemtoRegE  in  1  Execute instruction is a load.
- RegWE  in  1  Execute instruction writes a register.
- WA3E  in  4  Execute destination register.
- RA1D  in  4  Decode source register 1.
- RA2D  in  4  Decode source register 2.
- PCSrcE  in  1  PC redirect resolved in Execute (taken branch or PC write).
- mc_start  out  1  one-cycle start pulse to the multi-cycle unit.
- StallF  out  1  hold PC.
- StallD  out  1  hold the F/D register.
- StallE  out  1  hold the D→E register.
- FlushD  out  1  refresh the F/D register.
- FlushE  out  1  refresh the D→E register.
- mc_busy  out  1  high in ISSUE/WAIT.
- mc_timeout  out  1  sticky watchdog error flag.
- busy_cnt  out  CNT_W  saturating count of cycles in the current or last WAIT.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - State goes to IDLE; busy_cnt=0; mc_timeout=0.
  - All outputs are forced to 0 while rst_n=0, regardless of inputs.
  - Reset in ISSUE or WAIT abandons the operation; no COMMIT occurs.
- FSM states: IDLE, WAIT, COMMIT (registered state).
- IDLE:
  - If M_StartE=1: mc_start=1, StallF=StallD=StallE=1, mc_busy=1, busy_cnt cleared to 0; next state WAIT.
  - Otherwise the hazard logic below applies.
- WAIT:
  - StallF=StallD=StallE=1, mc_busy=1, mc_start=0.
  - busy_cnt increments each cycle and saturates at 2^CNT_W−1.
  - mc_done=1 → next state COMMIT.
  - TIMEOUT_CYCLES≠0 and busy_cnt reaches TIMEOUT_CYCLES−1 without mc_done → mc_timeout set (sticky until reset); next state COMMIT.
- COMMIT:
  - All stalls 0, mc_busy=0; the multi-cycle instruction leaves Execute at the end of this cycle.
  - M_StartE is ignored in this cycle (same instruction); next state IDLE.
- Latency: an op whose mc_done arrives N cycles after mc_start holds the pipeline N+1 cycles (ISSUE cycle plus N−1 WAIT cycles plus 1), then one COMMIT cycle.
- mc_done rules:
  - Sampled only in WAIT.
  - Ignored in IDLE and COMMIT.
  - Ignored in the cycle mc_start is asserted; the unit has a minimum latency of 1.
- Hazard logic, active only in IDLE with M_StartE=0 (combinational):
  - lwstall = MemtoRegE & RegWE & (WA3E==RA1D | WA3E==RA2D).
  - StallF = StallD = lwstall.
  - FlushE = lwstall | PCSrcE.
  - FlushD = PCSrcE.
- In WAIT and COMMIT: FlushD=FlushE=0.
  - PCSrcE is never 1 for a multi-cycle instruction.
  - A PCSrcE seen in COMMIT is still honoured: FlushD=FlushE=PCSrcE.
- Simultaneous PCSrcE and lwstall in IDLE: FlushE=1, FlushD=1, StallF=StallD=1.
  - The flush of D wins over the stall; the PC hold is overridden because the PC mux selects the branch target.
- mc_timeout does not block later operations; the next M_StartE is issued normally.

Test Plan:
- Reset behaviour: rst_n=0 with M_StartE=1 → all outputs 0. Release reset → mc_start=1 in the first cycle, state WAIT.
- Multi-cycle op: M_StartE=1, mc_done pulsed 5 cycles after mc_start.
  - Stalls high for 6 cycles, then one COMMIT cycle with stalls low.
  - busy_cnt=4 at COMMIT; no second mc_start.
- Load-use hazard: MemtoRegE=1, RegWE=1, WA3E=4'd3, RA2D=4'd3 → StallF=StallD=FlushE=1 for one cycle. With RA1D=RA2D=4'd5 → all 0.
- Branch during load-use: PCSrcE=1 with the lwstall case → FlushD=1, FlushE=1.
- Watchdog: TIMEOUT_CYCLES=10 and no mc_done.
  - mc_timeout rises after 10 WAIT cycles; COMMIT follows.
  - A second M_StartE issues mc_start normally with mc_timeout still 1.
- Reset mid-operation: rst_n pulsed low in WAIT cycle 3 → state IDLE, busy_cnt=0, stalls 0 immediately. A later mc_done is ignored.
